// File: rtl/iobus_n_connect.sv
// PDP-6 IO bus fan-out/fan-in: one IOB master to NSLAVE device slaves with
// per-slave device-code decode, registered read-back, PI sync and reset stretch.
module iobus_n_connect #(
  parameter int          NSLAVE      = 4,
  parameter logic [55:0] DEV_CODES   = 56'h0,
  parameter logic [7:0]  DEV_DECODE  = 8'hFF,
  parameter int          RST_STRETCH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m_iob_poweron,
  input  logic                   m_iob_reset,
  input  logic                   m_datao_clear,
  input  logic                   m_datao_set,
  input  logic                   m_cono_clear,
  input  logic                   m_cono_set,
  input  logic                   m_iob_fm_datai,
  input  logic                   m_iob_fm_status,
  input  logic [3:9]             m_ios,
  input  logic [0:35]            m_iob_write,
  output logic [1:7]             m_pi_req,
  output logic [0:35]            m_iob_read,
  output logic                   m_sel_err,
  output logic [NSLAVE-1:0]      s_iob_poweron,
  output logic [NSLAVE-1:0]      s_iob_reset,
  output logic [NSLAVE-1:0]      s_datao_clear,
  output logic [NSLAVE-1:0]      s_datao_set,
  output logic [NSLAVE-1:0]      s_cono_clear,
  output logic [NSLAVE-1:0]      s_cono_set,
  output logic [NSLAVE-1:0]      s_iob_fm_datai,
  output logic [NSLAVE-1:0]      s_iob_fm_status,
  output logic [NSLAVE*7-1:0]    s_ios,
  output logic [NSLAVE*36-1:0]   s_iob_write,
  input  logic [NSLAVE*7-1:0]    s_pi_req,
  input  logic [NSLAVE*36-1:0]   s_iob_read
);

  // stb bit order: 0 datao_clear, 1 datao_set, 2 cono_clear, 3 cono_set, 4 fm_datai, 5 fm_status
  logic [5:0]           stb_d, stb_q;
  logic [NSLAVE-1:0]    match_d, sel_q;
  logic [0:35]          read_d, read_q;
  logic [NSLAVE*7-1:0]  pi1_q, pi2_q;
  logic [1:7]           pi_or;
  logic                 rst_prev_q;
  logic [3:0]           cnt_d, cnt_q;
  logic                 err_d, err_q;
  logic [3:0]           nsel;
  logic                 rd_en;

  assign stb_d = {m_iob_fm_status, m_iob_fm_datai, m_cono_set,
                  m_cono_clear, m_datao_set, m_datao_clear};
  assign rd_en = stb_q[4] | stb_q[5];

  always_comb begin
    match_d = '0;
    read_d  = m_iob_write;
    pi_or   = '0;
    nsel    = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      match_d[i] = (m_ios == DEV_CODES[i*7 +: 7]) | ~DEV_DECODE[i];
      if (sel_q[i] && rd_en)
        read_d = read_d | s_iob_read[i*36 +: 36];
      pi_or = pi_or | pi2_q[i*7 +: 7];
      // Broadcast (legacy) slaves are excluded from the duplicate-select count.
      nsel = nsel + 4'(sel_q[i] & DEV_DECODE[i]);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_iob_reset && !rst_prev_q)
      cnt_d = 4'(RST_STRETCH);
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  // Clear has priority over a simultaneous set.
  always_comb begin
    err_d = err_q;
    if (m_iob_reset)
      err_d = 1'b0;
    else if ((nsel > 4'd1) && (stb_q != 6'd0))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_q      <= '0;
      sel_q      <= '0;
      read_q     <= '0;
      pi1_q      <= '0;
      pi2_q      <= '0;
      rst_prev_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      stb_q      <= stb_d;
      sel_q      <= match_d;
      read_q     <= read_d;
      pi1_q      <= s_pi_req;
      pi2_q      <= pi1_q;
      rst_prev_q <= m_iob_reset;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign m_iob_read      = read_q;
  assign m_pi_req        = pi_or;
  assign m_sel_err       = err_q;
  assign s_iob_poweron   = {NSLAVE{m_iob_poweron}};
  assign s_iob_reset     = {NSLAVE{m_iob_reset | (cnt_q != 4'd0)}};
  assign s_ios           = {NSLAVE{m_ios}};
  assign s_iob_write     = {NSLAVE{m_iob_write}};
  assign s_datao_clear   = sel_q & {NSLAVE{stb_q[0]}};
  assign s_datao_set     = sel_q & {NSLAVE{stb_q[1]}};
  assign s_cono_clear    = sel_q & {NSLAVE{stb_q[2]}};
  assign s_cono_set      = sel_q & {NSLAVE{stb_q[3]}};
  assign s_iob_fm_datai  = sel_q & {NSLAVE{stb_q[4]}};
  assign s_iob_fm_status = sel_q & {NSLAVE{stb_q[5]}};

endmodule

// File: doc/iobus_n_connect.md
Name: iobus_n_connect

Overview:
Parametrised PDP-6 IO bus fan-out/fan-in between one master (the processor IOB side) and NSLAVE device slaves.
- Master strobes and select/write data fan out to every slave.
- Per-slave device-code decode gates the CONO/DATAO/DATAI/CONI strobes to the addressed slave only.
- Read data is registered from the addressed slave(s); PI requests are synchronised and ORed.
- Iob reset is stretched to a minimum length; duplicate-address selection is flagged.

Parameters:
- NSLAVE, 4, number of slave ports (1..8).
- DEV_CODES, 56'h0, NSLAVE*7-bit packed device codes. Slave i code = DEV_CODES[i*7 +: 7]; its MSB matches ios bit 3, its LSB matches ios bit 9.
- DEV_DECODE, 8'hFF, per-slave enable. 1 = gate strobes by code match; 0 = slave always selected (legacy broadcast).
- RST_STRETCH, 4, minimum s_iob_reset length in clocks (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- m_iob_poweron  in  1  master power-on level
- m_iob_reset  in  1  master IO reset
- m_datao_clear, m_datao_set, m_cono_clear, m_cono_set  in  1 each  master write strobes
- m_iob_fm_datai, m_iob_fm_status  in  1 each  master read strobes
- m_ios  in  [3:9]  device select
- m_iob_write  in  [0:35]  master write data
- m_pi_req  out  [1:7]  ORed synchronised PI requests
- m_iob_read  out  [0:35]  registered read data
- m_sel_err  out  1  sticky: more than one decode-enabled slave matched
- s_iob_poweron, s_iob_reset  out  NSLAVE  per-slave power-on/reset
- s_datao_clear, s_datao_set, s_cono_clear, s_cono_set, s_iob_fm_datai, s_iob_fm_status  out  NSLAVE each  gated strobes
- s_ios  out  NSLAVE*7  select copy per slave
- s_iob_write  out  NSLAVE*36  write data per slave
- s_pi_req  in  NSLAVE*7  per-slave PI requests
- s_iob_read  in  NSLAVE*36  per-slave read data

Packed slice convention: slave i 36-bit slice bits [i*36+35 : i*36] carry PDP bits 0..35. Slice bit i*36+35 is PDP bit 0. The 7-bit slices follow the same rule (high end = lowest PDP index).

Behaviour:
- All registers clear on reset: sel_q=0, strobe regs=0, m_iob_read=0, PI sync=0, m_sel_err=0, stretch counter=0.
- s_iob_poweron[i] = m_iob_poweron, combinational.
- s_ios slice = m_ios, combinational.
- s_iob_write slice = m_iob_write, combinational.
- Decode: match[i] = (m_ios == code_i) | ~DEV_DECODE[i]. sel_q <= match each clock; one-cycle latency.
- Strobe registers: each master strobe is registered once (stb_q). Output s_X[i] = stb_q & sel_q[i].
  - Every slave strobe therefore lags the master by exactly 1 clock and stays aligned with sel_q.
  - A strobe falls 1 clock after the master strobe falls.
  - If m_ios changes while a strobe is held, the gating follows the new sel_q on the next cycle; no latch-on-rise.
- Read path: each clock, m_iob_read <= m_iob_write | OR over i of (s_iob_read slice_i & {36{sel_q[i] & (fmdatai_q | fmstatus_q)}}).
  - fmdatai_q and fmstatus_q are the registered master read strobes.
  - Read latency is 2 clocks from the master read strobe, which gives the slave one cycle to respond.
  - The write-data OR term is always present, preserving the wired-OR bus semantics.
- PI: each s_pi_req bit passes a 2-flop synchroniser. m_pi_req = OR of the second-stage flops over all slaves. Latency 2 clocks assert and 2 clocks deassert.
- Reset stretch:
  - A rising edge of m_iob_reset loads cnt = RST_STRETCH.
  - cnt decrements to 0, one step per clock.
  - s_iob_reset[i] (all i) = m_iob_reset | (cnt != 0), combinational.
  - A new rising edge during a count reloads cnt.
  - The reset pulse is never gated by decode.
- m_sel_err:
  - Sets when more than one bit of sel_q is set among decode-enabled slaves while any strobe in stb_q is active.
  - Clears only on reset or on m_iob_reset high.
  - If set and clear occur in the same cycle, clear wins.
  - Legacy (DEV_DECODE=0) slaves never contribute to m_sel_err.
- Reset mid-operation clears all registered outputs in the next cycle. In-flight strobes are dropped with no partial pulses.

Test Plan:
- NSLAVE=4, codes 01,02,03,04, all decode. m_ios=7'o02, m_cono_set held 3 clocks -> s_cono_set=4'b0010 for 3 clocks starting 1 clock later; other slaves 0.
- m_ios=7'o03, m_iob_fm_datai high. Slave 2 read=36'o123456701234, others 36'o777777777777, m_iob_write=0 -> m_iob_read=36'o123456701234 from 2 clocks after strobe rise; returns 0 2 clocks after fall.
- DEV_DECODE=4'b1110 (slave 0 broadcast), m_ios=7'o04, datao_set -> s_datao_set=4'b1001. m_sel_err stays 0.
- Codes 05,05,06,07, m_ios=7'o05, cono_clear pulse -> s_cono_clear=4'b0011 and m_sel_err=1, sticky. 1-clock m_iob_reset -> m_sel_err=0; s_iob_reset=4'b1111 for RST_STRETCH+1=5 clocks.
- Slave 3 PI bit 4 rises -> m_pi_req=7'b0001000 after 2 clocks. Assert reset mid-request -> m_pi_req=0 next clock; reassert follows 2 clocks after reset release.
